pulse_width_decoder: RTL
========================

# pulse_width_decoder

- Receive side of the fixed-length pulse signalling used across the design.
- Samples an asynchronous `pulse_in` line and measures how many `clk` cycles each high pulse lasts.
- Reports the width with a one-cycle strobe, or flags the pulse as too short or too long.
- Sits at the far end of a pulse generator, typically in another block or clock domain, and turns pulse lengths back into numeric codes.

## Interface
Parameters:
- `MAX_CYCLES`, default 32: longest legal pulse width in cycles; must be ≥ 2.
- `MIN_CYCLES`, default 2: shortest legal pulse width; must satisfy 1 ≤ `MIN_CYCLES` ≤ `MAX_CYCLES`.
- `W_WIDTH`, default `$clog2(MAX_CYCLES+1)`: derived localparam, not overridable. Equals 6 for the defaults.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pulse_in` input 1: asynchronous pulse line.
- `width_out` output `W_WIDTH`: width of the last legal pulse; held until the next legal report.
- `width_valid` output 1: one-cycle strobe; `width_out` is new this cycle.
- `too_short` output 1: one-cycle strobe for a pulse shorter than `MIN_CYCLES`.
- `too_long` output 1: one-cycle strobe for a pulse longer than `MAX_CYCLES`.
- `busy` output 1: high while a pulse is being measured or an overlong pulse is being drained.

## Operation
- **Synchronizer.** `pulse_in` goes through two flops (`s1`, `s2`). A third flop `s3` holds the previous `s2`.
  - Rise is detected when `s2 & ~s3`.
  - All three flops reset to 1, so a pulse already high when reset releases is ignored; only a fresh low→high transition starts a measurement.
- **FSM states:** IDLE, MEASURE, DRAIN.
  - **IDLE:** on rise → MEASURE with `cnt` = 1. Otherwise stay.
  - **MEASURE, `s2` = 1:**
    - If `cnt` == `MAX_CYCLES` → DRAIN and strobe `too_long`.
    - Otherwise `cnt` = `cnt` + 1.
  - **MEASURE, `s2` = 0:** pulse has ended → IDLE.
    - If `cnt` < `MIN_CYCLES`, strobe `too_short`; `width_out` is unchanged.
    - Otherwise load `width_out` = `cnt` and strobe `width_valid`.
  - **DRAIN:** wait for `s2` = 0 → IDLE. No further strobes.
- `cnt` is `W_WIDTH` bits, never exceeds `MAX_CYCLES`, and never wraps.
- `busy` = (state ≠ IDLE), registered alongside the state.
- At most one of `width_valid`, `too_short`, `too_long` is high in any cycle.
- **Back-to-back pulses:** a single low cycle between pulses is enough. The IDLE entered on the report edge detects the next rise normally, so no pulse is lost.
- **Reset mid-pulse:**
  - FSM returns to IDLE; all strobes go to 0.
  - `width_out` resets to 0.
  - The in-progress pulse is discarded, because the synchronizer flops reset to 1.

## Timing
- All outputs are registered.
- **Reset values:** `width_out` = 0, `width_valid` = 0, `too_short` = 0, `too_long` = 0, `busy` = 0.
- **Width definition:** a pulse sampled high on W consecutive rising edges E0..E(W-1) and low at EW reports width W.
- **Report latency:** the strobe and new `width_out` are visible after edge E(W+2), i.e. 2 cycles after the first low sample.
- **`busy` timing:** rises after E2; falls together with the report strobe.
- **`too_long` timing:** asserts after edge E(MAX_CYCLES+2), while the line is still high, once the pulse has been seen high for `MAX_CYCLES`+1 samples.
- A pulse of exactly `MAX_CYCLES` reports `MAX_CYCLES` with `width_valid`. It is not an error.

## Structure
- **Package `pulse_pkg`:**
  - State enum `pwd_state_t` (IDLE, MEASURE, DRAIN).
  - Shared defaults `PULSE_MAX_DEFAULT` = 32 and `PULSE_MIN_DEFAULT` = 2. Generator and decoder both use these.
- **Sub-module `sync_2ff`:** a two-flop synchronizer with a reset-value parameter. It is reused by other async inputs.
- The edge-detect flop, FSM, and counter stay in the top module.

## Test plan
- **Nominal pulse.** Reset, then hold `pulse_in` high for 32 cycles → one `width_valid` strobe with `width_out` = 32, exactly 2 cycles after the first low sample; `busy` falls on the same edge.
- **Minimum and short.** Pulse of 2 cycles → `width_valid`, `width_out` = 2. Then a 1-cycle pulse → `too_short` only, `width_out` stays 2.
- **Overlong.** Pulse of 40 cycles → a single `too_long` strobe 34 edges after the first high sample; `busy` stays high until 2 cycles after the fall; no `width_valid`.
- **Back-to-back.** Pulses of 5 high / 1 low / 7 high → `width_valid` with 5, then `width_valid` with 7. No strobes lost or merged.
- **Reset mid-pulse.** Assert `rst` at cycle 10 of a 20-cycle pulse and release while the line is still high → all outputs 0 and no report for that pulse. The next 4-cycle pulse reports 4.
- **Parameter sweep.** `MAX_CYCLES` = 3, `MIN_CYCLES` = 1; widths 1, 3, 4 → `width_valid` 1, `width_valid` 3, `too_long`.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and defaults for the fixed-length pulse signalling.
// Used by both the pulse generator and pulse_width_decoder.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DRAIN   = 2'd2
    } pwd_state_t;

    localparam int PULSE_MAX_DEFAULT = 32;
    localparam int PULSE_MIN_DEFAULT = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, rst (async active-high), d (async in), q (synced out).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pulse_width_decoder.sv
// Measures high-pulse widths on an async line in clk cycles and reports them.
// Ports: clk, rst, pulse_in; width_out/width_valid, too_short, too_long, busy.
module pulse_width_decoder
    import pulse_pkg::*;
#(
    parameter  int MAX_CYCLES = PULSE_MAX_DEFAULT,
    parameter  int MIN_CYCLES = PULSE_MIN_DEFAULT,
    localparam int W_WIDTH    = $clog2(MAX_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pulse_in,
    output logic [W_WIDTH-1:0] width_out,
    output logic               width_valid,
    output logic               too_short,
    output logic               too_long,
    output logic               busy
);

    localparam logic [W_WIDTH-1:0] MAX_W = W_WIDTH'(MAX_CYCLES);
    localparam logic [W_WIDTH-1:0] MIN_W = W_WIDTH'(MIN_CYCLES);
    localparam logic [W_WIDTH-1:0] ONE_W = W_WIDTH'(1);

    pwd_state_t         state, state_nxt;
    logic [W_WIDTH-1:0] cnt, cnt_nxt;
    logic [W_WIDTH-1:0] width_nxt;
    logic               wv_nxt, ts_nxt, tl_nxt;
    logic               s2, s3, rise;

    // Reset value 1 so a line already high at reset release is not a rise.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pulse_in),
        .q   (s2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s3 <= 1'b1;
        else     s3 <= s2;
    end

    assign rise = s2 & ~s3;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        width_nxt = width_out;
        wv_nxt    = 1'b0;
        ts_nxt    = 1'b0;
        tl_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                    cnt_nxt   = ONE_W;
                end
            end
            MEASURE: begin
                if (s2) begin
                    // Saturate at MAX; one more high sample is overlong.
                    if (cnt == MAX_W) begin
                        state_nxt = DRAIN;
                        tl_nxt    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + ONE_W;
                    end
                end else begin
                    state_nxt = IDLE;
                    if (cnt < MIN_W) begin
                        ts_nxt = 1'b1;
                    end else begin
                        width_nxt = cnt;
                        wv_nxt    = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!s2) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            width_out   <= '0;
            width_valid <= 1'b0;
            too_short   <= 1'b0;
            too_long    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            width_out   <= width_nxt;
            width_valid <= wv_nxt;
            too_short   <= ts_nxt;
            too_long    <= tl_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule
